cu_micro_sequencer: RTL and testbench

Microprogram sequencer for the microcoded control unit. It holds the control address register (CAR) and drives the control-memory read address. Each cycle it computes the next CAR from the 4-bit sequencing field (control word bits [19:16]) returned by the control buffer register, the IR opcode and the ALU flags. It sits between the IR/flag logic and the control memory, closing the microprogram loop with the control buffer register.

---
 rtl/cu_micro_sequencer.sv | 151 +++++++++++++++
 tb/tb_cu_micro_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_micro_sequencer.sv
// Microprogram sequencer for the microcoded control unit.
// Holds the control address register (CAR) and computes the next control
// memory address each cycle from the sequencing field of the current control
// word, the IR opcode and the ALU flags.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   start        level; leaves IDLE/HALT and enters the fetch microroutine
//   stall        memory/bus not ready; freezes the sequencer
//   ctrl_signal  sequencing field (control word bits [19:16]) at car_addr
//   opcode       opcode field of IR, used for DECODE dispatch
//   flag_zero    ACC == 0, used by BRZ
//   flag_neg     ACC sign bit, used by BRN
//   car_addr     registered CAR; control-memory read address
//   running      high in RUN
//   halted       high in HALT
//   seq_err      one-cycle pulse on a sequencing fault
//   instr_count  number of DECODE dispatches, wraps
module cu_micro_sequencer #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned OPC_W          = 8,
  parameter int unsigned DISPATCH_SHIFT = 2,
  parameter int unsigned FETCH_ADDR     = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [3:0]        ctrl_signal,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              flag_zero,
  input  logic              flag_neg,
  output logic [ADDR_W-1:0] car_addr,
  output logic              running,
  output logic              halted,
  output logic              seq_err,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned        DISP_W = OPC_W + DISPATCH_SHIFT;
  localparam logic [ADDR_W-1:0]  FETCH  = ADDR_W'(FETCH_ADDR);
  localparam logic [ADDR_W-1:0]  CAR_MAX = {ADDR_W{1'b1}};

  // Sequencing field encodings
  localparam logic [3:0] SEQ_INC    = 4'h0;
  localparam logic [3:0] SEQ_FETCH  = 4'h1;
  localparam logic [3:0] SEQ_DECODE = 4'h2;
  localparam logic [3:0] SEQ_BRZ    = 4'h3;
  localparam logic [3:0] SEQ_BRN    = 4'h4;
  localparam logic [3:0] SEQ_HALT   = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_car;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_running;
  logic                r_halted;
  logic                r_seq_err;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_car_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_err_nxt;
  logic [ADDR_W-1:0]   w_car_inc;
  logic [DISP_W-1:0]   w_opc_wide;
  logic [ADDR_W-1:0]   w_dispatch;

  assign w_car_inc  = r_car + ADDR_W'(1);
  // Widen before shifting so no opcode bits are lost ahead of the final truncation
  assign w_opc_wide = DISP_W'(opcode);
  assign w_dispatch = ADDR_W'(w_opc_wide << DISPATCH_SHIFT);

  // State, CAR, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_car     <= FETCH;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_car     <= w_car_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALT);
      r_seq_err <= w_err_nxt;
    end
  end

  // Next-state and next-CAR decode
  always_comb begin
    w_state_nxt = r_state;
    w_car_nxt   = r_car;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_car_nxt   = FETCH;
        end
      end

      ST_RUN: begin
        // Stall freezes everything, including the decode of the current word
        if (!stall) begin
          case (ctrl_signal)
            SEQ_INC: begin
              w_car_nxt = w_car_inc;
              w_err_nxt = (r_car == CAR_MAX);
            end
            SEQ_FETCH: w_car_nxt = FETCH;
            SEQ_DECODE: begin
              w_car_nxt = w_dispatch;
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            SEQ_BRZ:  w_car_nxt = flag_zero ? FETCH : w_car_inc;
            SEQ_BRN:  w_car_nxt = flag_neg  ? FETCH : w_car_inc;
            SEQ_HALT: w_state_nxt = ST_HALT;
            default: begin
              w_car_nxt = FETCH;
              w_err_nxt = 1'b1;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_car_nxt   = FETCH;
      end
    endcase
  end

  assign car_addr    = r_car;
  assign running     = r_running;
  assign halted      = r_halted;
  assign seq_err     = r_seq_err;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_cu_micro_sequencer.sv
// Testbench for cu_micro_sequencer: a control-memory array drives the
// sequencing field, a behavioural model predicts every cycle's outputs into a
// queue, and a monitor pops and compares after each rising edge.
module tb_cu_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic [3:0]  ctrl_signal;
  logic [7:0]  opcode;
  logic        flag_zero;
  logic        flag_neg;
  logic [7:0]  car_addr;
  logic        running;
  logic        halted;
  logic        seq_err;
  logic [15:0] instr_count;

  cu_micro_sequencer #(
    .ADDR_W(8), .OPC_W(8), .DISPATCH_SHIFT(2), .FETCH_ADDR(0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .ctrl_signal(ctrl_signal), .opcode(opcode),
    .flag_zero(flag_zero), .flag_neg(flag_neg),
    .car_addr(car_addr), .running(running), .halted(halted),
    .seq_err(seq_err), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [7:0]  car;
    logic        run;
    logic        hlt;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] rom [256];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = halt
  int m_mode = 0;
  int m_car  = 0;
  int m_cnt  = 0;
  int m_err  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle once expectations exist
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("car_addr",    int'(car_addr),    int'(e.car));
        check("running",     int'(running),     int'(e.run));
        check("halted",      int'(halted),      int'(e.hlt));
        check("seq_err",     int'(seq_err),     int'(e.err));
        check("instr_count", int'(instr_count), int'(e.cnt));
      end
    end
  end

  // Apply one cycle of stimulus, advance the model and push its prediction
  task automatic cyc(input bit rst, input bit st, input bit sl,
                     input int opc, input bit fz, input bit fn);
    int   code;
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    start       = st;
    stall       = sl;
    opcode      = 8'(opc);
    flag_zero   = fz;
    flag_neg    = fn;
    ctrl_signal = rom[m_car];
    code        = int'(rom[m_car]);
    m_err       = 0;
    if (!rst) begin
      m_mode = 0; m_car = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (st) begin m_mode = 1; m_car = 0; end
    end else if (!sl) begin
      case (code)
        0: begin
          if (m_car == 255) m_err = 1;
          m_car = (m_car + 1) % 256;
        end
        1: m_car = 0;
        2: begin
          m_car = (opc * 4) % 256;
          m_cnt = (m_cnt + 1) % 65536;
        end
        3: m_car = fz ? 0 : (m_car + 1) % 256;
        4: m_car = fn ? 0 : (m_car + 1) % 256;
        5: m_mode = 2;
        default: begin m_car = 0; m_err = 1; end
      endcase
    end
    e.car = 8'(m_car);
    e.run = (m_mode == 1);
    e.hlt = (m_mode == 2);
    e.err = 1'(m_err);
    e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic step(input int opc, input bit fz, input bit fn);
    cyc(1'b1, 1'b0, 1'b0, opc, fz, fn);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; ctrl_signal = 4'h0;
    opcode = 8'h00; flag_zero = 1'b0; flag_neg = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 4'h1;
    rom[0] = 4'h0; rom[1] = 4'h0; rom[2] = 4'h1;

    // Reset, idle hold, then start into INC,INC,FETCH
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 0, 0, 0);  // start ignored in RUN

    // DECODE dispatch and BRZ/BRN both ways
    rom[2] = 4'h2; rom[8'h14] = 4'h3; rom[8'h15] = 4'h4; rom[8'h16] = 4'h1;
    rom[4] = 4'h1;
    while (m_car != 2) step(0, 0, 0);
    step(8'h05, 0, 0);          // -> 0x14
    step(0, 1, 0);              // BRZ taken -> 0
    step(0, 0, 0); step(0, 0, 0);
    step(8'h05, 0, 0);          // -> 0x14
    step(0, 0, 1);              // BRZ not taken -> 0x15
    step(0, 1, 1);              // BRN taken -> 0
    step(0, 0, 0); step(0, 0, 0);
    step(8'h05, 0, 0);
    step(0, 0, 0);              // -> 0x15
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 8'h07, 1, 1);  // stalled at 0x15
    step(0, 1, 0);              // BRN not taken -> 0x16
    step(0, 0, 0);              // FETCH -> 0
    step(0, 0, 0); step(0, 0, 0);
    step(8'h41, 0, 0);          // truncated dispatch -> 0x04
    step(0, 0, 0);              // FETCH -> 0

    // HALT word, hold, restart
    rom[8'h20] = 4'h5;
    step(0, 0, 0); step(0, 0, 0);
    step(8'h08, 0, 0);          // -> 0x20
    step(0, 0, 0);              // HALT
    repeat (5) step(0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 0);

    // Reserved code
    rom[0] = 4'hA;
    step(0, 0, 0);
    rom[0] = 4'h0;
    step(0, 0, 0);
    step(0, 0, 0);

    // INC wrap at 0xFF
    for (int i = 8'hFC; i < 256; i++) rom[i] = 4'h0;
    step(8'h3F, 0, 0);          // 2 -> 0xFC
    repeat (5) step(0, 0, 0);   // 0xFD..0xFF, wrap, 1

    // Reset mid-routine at 0x33
    for (int i = 8'h30; i < 8'h36; i++) rom[i] = 4'h0;
    step(0, 0, 0);              // 1 -> 2
    step(8'h0C, 0, 0);          // -> 0x30
    repeat (3) step(0, 0, 0);   // -> 0x33
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(0, 0, 0);

    // Randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        for (int i = 0; i < 256; i++) begin
          r = int'($urandom_range(0, 99));
          if      (r < 40) rom[i] = 4'h0;
          else if (r < 48) rom[i] = 4'h1;
          else if (r < 63) rom[i] = 4'h2;
          else if (r < 75) rom[i] = 4'h3;
          else if (r < 87) rom[i] = 4'h4;
          else if (r < 92) rom[i] = 4'h5;
          else             rom[i] = 4'($urandom_range(6, 15));
        end
      end
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, int'($urandom_range(0, 255)),
          1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
